muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default defines::DATA_WIDTH (32), operand/result width.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_i  input  1  request pulse; accepted only in IDLE.
REQ-005 SHALL have port funct3_i  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port operand1_i  input  WIDTH  rs1 / dividend / multiplicand.
REQ-007 SHALL have port operand2_i  input  WIDTH  rs2 / divisor / multiplier.
REQ-008 SHALL have port flush_i  input  1  abort in-flight operation (pipeline flush).
REQ-009 SHALL have port busy_o  output  1  high while an operation is in flight (BUSY state).
REQ-010 SHALL have port done_o  output  1  one-cycle pulse; result_o valid.
REQ-011 SHALL have port result_o  output  WIDTH  last completed result, held until next acceptance.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; IDLE->BUSY on accepted start, BUSY->DONE after 32 iterations, DONE->IDLE unconditionally next cycle.
REQ-013 SHALL accept start_i only when state is IDLE and flush_i is low; start_i in BUSY/DONE ignored, no queuing.
REQ-014 SHALL latch funct3_i, operand1_i, operand2_i at acceptance; later input changes have no effect on the result.
REQ-015 SHALL use a 6-bit iteration counter, cleared at acceptance, one iteration per cycle; done_o asserted exactly 33 cycles after the accepting edge (busy_o high for cycles 1..32).
REQ-016 SHALL compute multiplies by shift-add on absolute values into a 2*WIDTH product with final sign correction; MUL returns low WIDTH bits; MULH signed x signed high; MULHSU signed rs1 x unsigned rs2 high; MULHU unsigned high.
REQ-017 SHALL compute divides by restoring division on absolute values; DIV/REM quotient sign = sign1 XOR sign2, remainder sign = dividend sign; DIVU/REMU unsigned.
REQ-018 SHALL on divisor zero return quotient all-ones and remainder = dividend, bypassing iteration: IDLE->DONE, done_o the cycle after acceptance.
REQ-019 SHALL on signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF) return quotient 0x80000000, remainder 0, via the same 1-cycle bypass.
REQ-020 SHALL drive done_o high only while in DONE; result_o updated on the edge entering DONE.
REQ-021 SHALL on flush_i high in BUSY return to IDLE next edge, no done_o, result_o unchanged; flush_i in DONE forces IDLE (done_o already registered, not retracted).
REQ-022 SHALL give flush_i priority over start_i when both high in IDLE (no acceptance).

Reset
REQ-023 SHALL on rst_i high at an edge force state IDLE, counter 0, busy_o 0, done_o 0, result_o 0, regardless of current state (mid-operation reset discards work).
REQ-024 SHALL give rst_i priority over flush_i and start_i.

Structure
REQ-025 SHALL place in package defines: muldiv_op_e enum (funct3 encodings above), FUNCT7_MULDIV = 7'b0000001, MULDIV_CYCLES = 32.
REQ-026 SHALL be a single module; FSM, counter, shared shift register and sign fix-up in one block, no sub-module.

Verification
REQ-027 SHALL cover MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done_o exactly 33 cycles after accept, busy_o high 32 cycles.
REQ-028 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-029 SHALL cover DIV 0xFFFFFFEC / 3 -> 0xFFFFFFFA, REM -> 0xFFFFFFFE; DIVU 100 / 7 -> 14, REMU -> 2.
REQ-030 SHALL cover DIV 5 / 0 -> 0xFFFFFFFF, REM 5 / 0 -> 5, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, each with done_o one cycle after accept.
REQ-031 SHALL cover start_i re-pulsed and operands changed during BUSY -> result unchanged; flush_i at cycle 10 -> IDLE next cycle, no done_o, result_o holds prior value, new start accepted.
REQ-032 SHALL cover rst_i asserted at cycle 15 of a DIV -> busy_o, done_o, result_o all 0 after that edge, next start completes normally.

Source files
------------

// File: rtl/defines.sv
// rtl/defines.sv - shared widths, RV32M op encodings and FSM states for the mul/div unit
package defines;

  localparam int DATA_WIDTH = 32;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam int MULDIV_CYCLES = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide, one shift-add or restoring step per cycle
module muldiv_unit
  import defines::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] operand1_i,
  input  logic [WIDTH-1:0] operand2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [5:0] LAST_ITER = 6'(MULDIV_CYCLES - 1);

  muldiv_state_e    state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  muldiv_op_e       op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, step, prod_fix;
  logic [WIDTH:0]     div_hi;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_result;

  // acc holds {product_hi, multiplier} for multiplies and {remainder, quotient} for divides
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_hi   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = {1'b0, div_hi} - {2'b00, b_q};
    if (!div_diff[WIDTH+1]) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_hi[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
    step     = op_q[2] ? div_next : mul_next;
    prod_fix = (sa_q ^ sb_q) ? -step : step;
    quo_fix  = (sa_q ^ sb_q) ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem_fix  = sa_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:                       fix_result = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_result = quo_fix;
      default:                      fix_result = rem_fix;
    endcase
  end

  logic             in_div, in_sgn1, in_sgn2, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] a_abs, b_abs;
  muldiv_op_e       in_op;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;

    in_op    = muldiv_op_e'(funct3_i);
    in_div   = funct3_i[2];
    in_sgn1  = in_div ? ~funct3_i[0] : (in_op != OP_MULHU);
    in_sgn2  = in_div ? ~funct3_i[0] : (in_op == OP_MUL || in_op == OP_MULH);
    a_neg    = in_sgn1 & operand1_i[WIDTH-1];
    b_neg    = in_sgn2 & operand2_i[WIDTH-1];
    a_abs    = a_neg ? -operand1_i : operand1_i;
    b_abs    = b_neg ? -operand2_i : operand2_i;
    div_zero = in_div && (operand2_i == '0);
    div_ovf  = in_div && !funct3_i[0] && (operand1_i == {1'b1, {(WIDTH-1){1'b0}}})
               && (operand2_i == '1);

    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          op_d  = in_op;
          sa_d  = a_neg;
          sb_d  = b_neg;
          acc_d = {{WIDTH{1'b0}}, a_abs};
          b_d   = b_abs;
          cnt_d = '0;
          // architecturally defined corner cases skip the iteration entirely
          if (div_zero) begin
            result_d = funct3_i[1] ? operand1_i : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = funct3_i[1] ? '0 : operand1_i;
            state_d  = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) begin
            state_d  = S_DONE;
            result_d = fix_result;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      b_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == S_BUSY);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;
  import defines::*;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] operand1_i, operand2_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_last;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0]        sx, zx, sy, zy, p;
    logic signed [31:0] as, bs;
    logic               ovf;
    sx  = {{32{a[31]}}, a};
    zx  = {32'h0, a};
    sy  = {{32{b[31]}}, b};
    zy  = {32'h0, b};
    as  = a;
    bs  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (muldiv_op_e'(f))
      OP_MUL:    begin p = sx * sy; return p[31:0];  end
      OP_MULH:   begin p = sx * sy; return p[63:32]; end
      OP_MULHSU: begin p = sx * zy; return p[63:32]; end
      OP_MULHU:  begin p = zx * zy; return p[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(as / bs);
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(as % bs);
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    logic ovf;
    ovf = !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    return (f[2] && (b == 0 || ovf)) ? 1 : 33;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {31'b0, done_o}, 32'h0);
        end else begin
          e = sb.pop_front();
          check("result", result_o, e.res);
          check("done_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    int n = 0;
    @(negedge clk_i);
    while ((busy_o || done_o) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    start_i    = 1'b1;
    funct3_i   = f;
    operand1_i = a;
    operand2_i = b;
    if (push) sb.push_back('{model(f, a, b), model_lat(f, a, b), cyc});
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int bc);
    int n = 0;
    bc = 0;
    while (done_o !== 1'b1 && n < 100) begin
      if (busy_o) bc++;
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_100");
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int bc;
    issue(f, a, b, 1'b1);
    wait_done(bc);
    check("busy_cycles", 32'(bc), (model_lat(f, a, b) == 1) ? 32'd0 : 32'd32);
    exp_last = model(f, a, b);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  dir_f[12] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110,
                             3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
  logic [31:0] dir_a[12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dir_b[12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd3, 32'd3, 32'd7, 32'd7,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin : driver
    int bc;
    rst_i      = 1'b1;
    start_i    = 1'b0;
    flush_i    = 1'b0;
    funct3_i   = 3'b000;
    operand1_i = '0;
    operand2_i = '0;
    exp_last   = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_busy", {31'b0, busy_o}, 32'h0);
    check("reset_done", {31'b0, done_o}, 32'h0);
    check("reset_result", result_o, 32'h0);

    for (int i = 0; i < 12; i++) run_op(dir_f[i], dir_a[i], dir_b[i]);

    // restart and operand changes while busy must not disturb the running op
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1);
    repeat (3) @(negedge clk_i);
    start_i    = 1'b1;
    funct3_i   = 3'b101;
    operand1_i = $urandom;
    operand2_i = 32'h0;
    @(negedge clk_i);
    operand1_i = 32'd123;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(bc);
    exp_last = 32'hFFFF_FFEB;
    repeat (40) @(negedge clk_i);

    // flush at cycle 10
    issue(3'b100, 32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_busy", {31'b0, busy_o}, 32'h0);
    check("flush_done", {31'b0, done_o}, 32'h0);
    check("flush_result_hold", result_o, exp_last);
    repeat (40) @(negedge clk_i);
    run_op(3'b101, 32'd100, 32'd7);

    // flush wins over start in idle
    @(negedge clk_i);
    start_i  = 1'b1;
    flush_i  = 1'b1;
    funct3_i = 3'b000;
    @(negedge clk_i);
    start_i = 1'b0;
    flush_i = 1'b0;
    check("flush_prio_busy", {31'b0, busy_o}, 32'h0);
    repeat (40) @(negedge clk_i);

    // reset at cycle 15 of a divide
    issue(3'b100, 32'hFFFF_FFEC, 32'd3, 1'b0);
    repeat (14) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_busy", {31'b0, busy_o}, 32'h0);
    check("midrst_done", {31'b0, done_o}, 32'h0);
    check("midrst_result", result_o, 32'h0);
    repeat (40) @(negedge clk_i);
    run_op(3'b110, 32'hFFFF_FFEC, 32'd3);

    for (int i = 0; i < 40; i++) run_op(3'($urandom_range(0, 7)), pick(), pick());

    repeat (5) @(negedge clk_i);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
